// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared widths, state encoding and pixel type for the framebuffer write path
package fb_pkg;

  localparam int FB_ADDR_W         = 19;
  localparam int FB_DATA_W         = 4;
  localparam int FB_PIXELS_DEFAULT = 384000;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } fbws_state_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_pixel_t;

endpackage

// File: rtl/fb_rr_pick2.sv
// rtl/fb_rr_pick2.sv - combinational round-robin picker granting up to two requesters per cycle
module fb_rr_pick2
  import fb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]           valid,
  input  logic [IDX_W-1:0]       rr,
  input  logic [N*FB_ADDR_W-1:0] addr,
  output logic                   g1_valid,
  output logic [IDX_W-1:0]       g1_idx,
  output logic                   g2_valid,
  output logic [IDX_W-1:0]       g2_idx,
  output logic [IDX_W-1:0]       rr_next
);

  logic [FB_ADDR_W-1:0] a [N];

  for (genvar i = 0; i < N; i++) begin : g_addr
    assign a[i] = addr[i*FB_ADDR_W +: FB_ADDR_W];
  end

  always_comb begin
    int j;
    int found;
    int nxt;
    g1_valid = 1'b0;
    g1_idx   = '0;
    g2_valid = 1'b0;
    g2_idx   = '0;
    rr_next  = rr;
    found    = 0;
    nxt      = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr) + k;
      if (j >= N) j = j - N;
      if (valid[j] && found == 0) begin
        g1_valid = 1'b1;
        g1_idx   = IDX_W'(j);
        found    = 1;
      end else if (valid[j] && found == 1) begin
        g2_valid = 1'b1;
        g2_idx   = IDX_W'(j);
        found    = 2;
      end
    end
    // Same-address pair: the later client waits so its write lands after the first one.
    if (g2_valid && (a[g2_idx] == a[g1_idx])) g2_valid = 1'b0;
    if (g2_valid) begin
      nxt     = int'(g2_idx) + 1;
      rr_next = (nxt >= N) ? '0 : IDX_W'(nxt);
    end else if (g1_valid) begin
      nxt     = int'(g1_idx) + 1;
      rr_next = (nxt >= N) ? '0 : IDX_W'(nxt);
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - shares the two framebuffer write ports between render clients and a post-swap clear engine
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int                   NUM_CLIENTS = 4,
  parameter int                   FB_PIXELS   = FB_PIXELS_DEFAULT,
  parameter logic [FB_DATA_W-1:0] CLEAR_COLOR = 4'h0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             vsync,
  input  logic                             clear_en,
  input  logic [NUM_CLIENTS-1:0]           req_valid,
  input  logic [NUM_CLIENTS*FB_ADDR_W-1:0] req_addr,
  input  logic [NUM_CLIENTS*FB_DATA_W-1:0] req_data,
  output logic [NUM_CLIENTS-1:0]           req_ready,
  output logic [FB_ADDR_W-1:0]             addr_wr1,
  output logic [FB_ADDR_W-1:0]             addr_wr2,
  output logic [FB_DATA_W-1:0]             data_wr1,
  output logic [FB_DATA_W-1:0]             data_wr2,
  output logic                             wr1_en,
  output logic                             wr2_en,
  output logic                             clear_busy,
  output logic                             clear_overrun,
  output logic                             addr_err
);

  localparam int                   IDX_W     = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [FB_ADDR_W-1:0] LAST_PAIR = FB_ADDR_W'(FB_PIXELS - 2);
  localparam logic [FB_ADDR_W:0]   PIX_LIM   = (FB_ADDR_W + 1)'(FB_PIXELS);

  fbws_state_t          state, state_n;
  logic                 vsync_q;
  logic                 swap;
  logic [FB_ADDR_W-1:0] cc, cc_n, cc_eff;
  logic [IDX_W-1:0]     rr, rr_n, rr_pick;
  logic                 g1_valid, g2_valid;
  logic [IDX_W-1:0]     g1_idx, g2_idx;
  fb_pixel_t            pix [NUM_CLIENTS];
  fb_pixel_t            p1, p2, p1_n, p2_n;
  logic                 ok1, ok2;
  logic                 w1_n, w2_n, ovr_n, aerr_n;

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
    assign pix[i] = {req_addr[i*FB_ADDR_W +: FB_ADDR_W], req_data[i*FB_DATA_W +: FB_DATA_W]};
  end

  fb_rr_pick2 #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid    (req_valid),
    .rr       (rr),
    .addr     (req_addr),
    .g1_valid (g1_valid),
    .g1_idx   (g1_idx),
    .g2_valid (g2_valid),
    .g2_idx   (g2_idx),
    .rr_next  (rr_pick)
  );

  assign swap       = vsync_q & ~vsync;
  assign clear_busy = (state == CLEAR);
  assign p1         = pix[g1_idx];
  assign p2         = pix[g2_idx];
  assign ok1        = {1'b0, p1.addr} < PIX_LIM;
  assign ok2        = {1'b0, p2.addr} < PIX_LIM;
  // A swap mid-clear restarts the wipe on the new back buffer in this very cycle.
  assign cc_eff     = swap ? '0 : cc;

  always_comb begin
    state_n   = state;
    cc_n      = cc;
    rr_n      = rr;
    p1_n      = '0;
    p2_n      = '0;
    w1_n      = 1'b0;
    w2_n      = 1'b0;
    ovr_n     = 1'b0;
    aerr_n    = 1'b0;
    req_ready = '0;
    case (state)
      ARB: begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
          req_ready[i] = (g1_valid && (g1_idx == IDX_W'(i))) ||
                         (g2_valid && (g2_idx == IDX_W'(i)));
        end
        if (g1_valid) begin
          p1_n = p1;
          w1_n = ok1;
        end
        if (g2_valid) begin
          p2_n = p2;
          w2_n = ok2;
        end
        // Out-of-range requests are still accepted so the client never stalls.
        aerr_n = (g1_valid && !ok1) || (g2_valid && !ok2);
        rr_n   = rr_pick;
        if (swap && clear_en) begin
          state_n = CLEAR;
          cc_n    = '0;
        end
      end
      CLEAR: begin
        ovr_n     = swap;
        w1_n      = 1'b1;
        w2_n      = 1'b1;
        p1_n.addr = cc_eff;
        p1_n.data = CLEAR_COLOR;
        p2_n.addr = cc_eff + FB_ADDR_W'(1);
        p2_n.data = CLEAR_COLOR;
        cc_n      = cc_eff + FB_ADDR_W'(2);
        if (cc_eff == LAST_PAIR) begin
          state_n = ARB;
          cc_n    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ARB;
      vsync_q       <= 1'b0;
      cc            <= '0;
      rr            <= '0;
      wr1_en        <= 1'b0;
      wr2_en        <= 1'b0;
      addr_wr1      <= '0;
      addr_wr2      <= '0;
      data_wr1      <= '0;
      data_wr2      <= '0;
      clear_overrun <= 1'b0;
      addr_err      <= 1'b0;
    end else begin
      state         <= state_n;
      vsync_q       <= vsync;
      cc            <= cc_n;
      rr            <= rr_n;
      wr1_en        <= w1_n;
      wr2_en        <= w2_n;
      addr_wr1      <= p1_n.addr;
      addr_wr2      <= p2_n.addr;
      data_wr1      <= p1_n.data;
      data_wr2      <= p2_n.data;
      clear_overrun <= ovr_n;
      addr_err      <= aerr_n;
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb/tb_fb_write_scheduler.sv - randomized and directed checks of fb_write_scheduler against a behavioural model
module tb_fb_write_scheduler;

  localparam int         N   = 4;
  localparam int         FBP = 256;
  localparam logic [3:0] CC  = 4'h5;

  logic            clock;
  logic            reset;
  logic            vsync;
  logic            clear_en;
  logic [N-1:0]    req_valid;
  logic [N*19-1:0] req_addr;
  logic [N*4-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic [18:0]     addr_wr1, addr_wr2;
  logic [3:0]      data_wr1, data_wr2;
  logic            wr1_en, wr2_en, clear_busy, clear_overrun, addr_err;

  fb_write_scheduler #(
    .NUM_CLIENTS (N),
    .FB_PIXELS   (FBP),
    .CLEAR_COLOR (CC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .vsync         (vsync),
    .clear_en      (clear_en),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .addr_wr1      (addr_wr1),
    .addr_wr2      (addr_wr2),
    .data_wr1      (data_wr1),
    .data_wr2      (data_wr2),
    .wr1_en        (wr1_en),
    .wr2_en        (wr2_en),
    .clear_busy    (clear_busy),
    .clear_overrun (clear_overrun),
    .addr_err      (addr_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_bad    = 0;

  // behavioural model state
  bit       m_clear;
  int       m_cc;
  int       m_rr;
  bit       m_vs_q;
  bit       ew1, ew2, eovr, eaerr;
  int       ea1, ea2, ed1, ed2;
  logic [3:0] ref_mem [FBP];
  logic [3:0] dut_mem [FBP];
  logic [N-1:0] acc;
  logic [N-1:0] last_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int c, input bit v, input int a, input int d);
    req_valid[c]          = v;
    req_addr[c*19 +: 19]  = 19'(a);
    req_data[c*4 +: 4]    = 4'(d);
  endtask

  function automatic int c_addr(input int c);
    return int'(req_addr[c*19 +: 19]);
  endfunction

  function automatic int c_data(input int c);
    return int'(req_data[c*4 +: 4]);
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_wr1_en"}, wr1_en, 0);
    check({tag, "_wr2_en"}, wr2_en, 0);
    check({tag, "_addr1"}, addr_wr1, 0);
    check({tag, "_addr2"}, addr_wr2, 0);
    check({tag, "_data1"}, data_wr1, 0);
    check({tag, "_data2"}, data_wr2, 0);
    check({tag, "_busy"}, clear_busy, 0);
    check({tag, "_ovr"}, clear_overrun, 0);
    check({tag, "_aerr"}, addr_err, 0);
  endtask

  // Asserts reset mid-cycle, checks outputs drop at once, releases off the clock edge.
  task automatic do_reset();
    reset     = 1'b0;
    vsync     = 1'b0;
    clear_en  = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    #2;
    check_zero("rst");
    check("rst_ready", req_ready, 0);
    @(posedge clock);
    #1;
    reset  = 1'b1;
    m_clear = 1'b0;
    m_cc    = 0;
    m_rr    = 0;
    m_vs_q  = 1'b0;
    acc     = '0;
  endtask

  // One clock: model the cycle from the current inputs, then check the registered results.
  task automatic run_cycle();
    int g1, g2, idx;
    bit swap;
    logic [N-1:0] eready;
    #1;
    swap = m_vs_q && !vsync;
    check("busy", clear_busy, m_clear);
    eready = '0;
    ew1 = 0; ew2 = 0; eovr = 0; eaerr = 0;
    ea1 = 0; ea2 = 0; ed1 = 0; ed2 = 0;
    if (!m_clear) begin
      g1 = -1;
      g2 = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (req_valid[idx]) begin
          if (g1 < 0) g1 = idx;
          else if (g2 < 0) g2 = idx;
        end
      end
      if (g2 >= 0 && c_addr(g2) == c_addr(g1)) g2 = -1;
      if (g1 >= 0) begin
        eready[g1] = 1'b1;
        ea1 = c_addr(g1);
        ed1 = c_data(g1);
        ew1 = (ea1 < FBP);
        if (!ew1) eaerr = 1;
        m_rr = (g1 + 1) % N;
      end
      if (g2 >= 0) begin
        eready[g2] = 1'b1;
        ea2 = c_addr(g2);
        ed2 = c_data(g2);
        ew2 = (ea2 < FBP);
        if (!ew2) eaerr = 1;
        m_rr = (g2 + 1) % N;
      end
      if (swap && clear_en) begin
        m_clear = 1;
        m_cc    = 0;
      end
    end else begin
      if (swap) begin
        m_cc = 0;
        eovr = 1;
      end
      ew1 = 1; ew2 = 1;
      ea1 = m_cc; ea2 = m_cc + 1;
      ed1 = CC; ed2 = CC;
      m_cc += 2;
      if (m_cc >= FBP) begin
        m_clear = 0;
        m_cc    = 0;
      end
    end
    m_vs_q = vsync;
    check("ready", req_ready, eready);
    last_ready = req_ready;
    acc = req_valid & eready;
    @(posedge clock);
    #1;
    check("wr1_en", wr1_en, ew1);
    check("wr2_en", wr2_en, ew2);
    if (ew1) begin
      check("addr_wr1", addr_wr1, ea1);
      check("data_wr1", data_wr1, ed1);
      ref_mem[ea1] = 4'(ed1);
    end
    if (ew2) begin
      check("addr_wr2", addr_wr2, ea2);
      check("data_wr2", data_wr2, ed2);
      ref_mem[ea2] = 4'(ed2);
    end
    check("overrun", clear_overrun, eovr);
    check("addr_err", addr_err, eaerr);
    if (wr1_en && int'(addr_wr1) < FBP) dut_mem[addr_wr1] = data_wr1;
    if (wr2_en && int'(addr_wr2) < FBP) dut_mem[addr_wr2] = data_wr2;
  endtask

  task automatic start_clear();
    vsync = 1'b1;
    run_cycle();
    vsync = 1'b0;
    run_cycle();
  endtask

  initial begin
    int n;
    int seq;
    for (int a = 0; a < FBP; a++) begin
      ref_mem[a] = '0;
      dut_mem[a] = '0;
    end
    reset     = 1'b1;
    vsync     = 1'b0;
    clear_en  = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    #1;
    do_reset();
    check_zero("post_rst");

    // single client write
    set_req(0, 1, 5, 4'hA);
    run_cycle();
    check("single_ready", last_ready, 4'b0001);
    check("single_wr1", wr1_en, 1);
    check("single_addr", addr_wr1, 5);
    check("single_data", data_wr1, 4'hA);
    check("single_wr2", wr2_en, 0);
    set_req(0, 0, 0, 0);
    run_cycle();

    // four clients streaming distinct addresses
    do_reset();
    seq = 0;
    for (int c = 0; c < N; c++) set_req(c, 1, c * 16, c);
    for (int cyc = 0; cyc < 8; cyc++) begin
      run_cycle();
      check("four_pair", last_ready, (cyc % 2 == 0) ? 4'b0011 : 4'b1100);
      check("four_both", wr1_en & wr2_en, 1);
      seq++;
      for (int c = 0; c < N; c++)
        if (acc[c]) set_req(c, 1, c * 16 + (seq % 16), seq);
    end

    // same-address ordering
    do_reset();
    set_req(1, 1, 100, 3);
    set_req(2, 1, 100, 7);
    run_cycle();
    check("same_first", last_ready, 4'b0010);
    check("same_data1", data_wr1, 3);
    check("same_single", wr2_en, 0);
    set_req(1, 0, 0, 0);
    run_cycle();
    check("same_second", last_ready, 4'b0100);
    check("same_data2", data_wr1, 7);
    set_req(2, 0, 0, 0);
    check("same_final", dut_mem[100], 7);

    // out-of-range request
    set_req(0, 1, FBP, 9);
    run_cycle();
    check("oob_ready", last_ready[0], 1);
    check("oob_wr1", wr1_en, 0);
    check("oob_err", addr_err, 1);
    set_req(0, 0, 0, 0);
    run_cycle();
    check("oob_err_once", addr_err, 0);

    // full clear with a client waiting
    clear_en = 1'b1;
    start_clear();
    check("clr_start", clear_busy, 1);
    set_req(3, 1, 40, 2);
    n = 0;
    while (clear_busy && n < 4 * FBP) begin
      run_cycle();
      n++;
    end
    check("clr_len", n, FBP / 2);
    run_cycle();
    check("clr_resume", last_ready[3], 1);
    set_req(3, 0, 0, 0);

    // overrun mid-clear
    start_clear();
    for (int i = 0; i < 10; i++) run_cycle();
    vsync = 1'b1;
    run_cycle();
    vsync = 1'b0;
    run_cycle();
    check("ovr_pulse", clear_overrun, 1);
    check("ovr_a1", addr_wr1, 0);
    check("ovr_a2", addr_wr2, 1);
    run_cycle();
    check("ovr_once", clear_overrun, 0);
    n = 0;
    while (clear_busy && n < 4 * FBP) begin
      run_cycle();
      n++;
    end
    check("ovr_end", clear_busy, 0);

    // reset in the middle of a clear
    start_clear();
    for (int i = 0; i < 20; i++) run_cycle();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check("rst_no_clear", clear_busy, 0);
    end

    // randomized traffic with swaps, overruns and clear_en changes
    do_reset();
    clear_en = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (acc[c] || !req_valid[c]) begin
          if ($urandom_range(0, 9) < 6) begin
            case ($urandom_range(0, 3))
              0:       set_req(c, 1, FBP - 4 + int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
              1:       set_req(c, 1, int'($urandom_range(0, FBP - 1)), int'($urandom_range(0, 15)));
              default: set_req(c, 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            endcase
          end else begin
            set_req(c, 0, 0, 0);
          end
        end
      end
      if ($urandom_range(0, 39) == 0) vsync = ~vsync;
      if ($urandom_range(0, 149) == 0) clear_en = ~clear_en;
      run_cycle();
    end

    for (int a = 0; a < FBP; a++) check("mem", dut_mem[a], ref_mem[a]);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
# fb_write_scheduler

Shares the back-buffer write ports of `framebuffer_master` (`addr_wr1/2`, `data_wr1/2`, `wr1_en/wr2_en`) between NUM_CLIENTS pixel producers, such as sprite and line renderers. It also runs a built-in clear engine that wipes the new back buffer after every buffer swap. The block sits between the render clients and `framebuffer_master` and tracks swaps from the same `vsync` falling edge that the framebuffer uses.

## Interface
- NUM_CLIENTS, 4: number of requesters, range 2..8.
- FB_PIXELS, 384000: framebuffer depth; must be even.
- CLEAR_COLOR, 4'h0: value written by the clear engine.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- vsync  in  1  same signal fed to `framebuffer_master`.
- clear_en  in  1  when high, a clear runs after each swap.
- req_valid  in  NUM_CLIENTS  per-client write request.
- req_addr  in  NUM_CLIENTS*19  packed pixel addresses; client i uses bits [19i+18:19i].
- req_data  in  NUM_CLIENTS*4  packed pixel values.
- req_ready  out  NUM_CLIENTS  per-client accept, combinational from valid and state.
- addr_wr1, addr_wr2  out  19  write addresses to the framebuffer.
- data_wr1, data_wr2  out  4  write data to the framebuffer.
- wr1_en, wr2_en  out  1  write strobes.
- clear_busy  out  1  high while in CLEAR.
- clear_overrun  out  1  one-cycle pulse when a swap arrives during CLEAR.
- addr_err  out  1  one-cycle pulse when an accepted request is dropped.

## Operation
- Swap detect: a registered copy of `vsync` is kept; `swap` = previous value 1 and current value 0.
- States are ARB and CLEAR. Reset enters ARB.
- ARB, with swap and clear_en high: go to CLEAR, clear counter `cc` = 0.
- ARB, with swap and clear_en low: stay in ARB.
- CLEAR, each cycle:
  - port 1 writes `cc`, port 2 writes `cc+1`, both with CLEAR_COLOR;
  - `cc` += 2;
  - after the cycle that writes FB_PIXELS-2 and FB_PIXELS-1, return to ARB.
- CLEAR, with a swap: pulse clear_overrun and restart at `cc` = 0 (the new back buffer). Do not leave CLEAR.
- In CLEAR, all req_ready are 0.
- ARB arbitration:
  - Round-robin pointer `rr`, reset 0.
  - Scan clients `rr`, `rr+1`, … modulo NUM_CLIENTS.
  - The first valid client gets port 1; the second valid client gets port 2.
  - If both granted addresses are equal, grant only the first. The second client waits, which preserves its write order.
  - req_ready is 1 exactly for granted clients. A handshake is valid && ready.
  - `rr` becomes (last granted index + 1) mod NUM_CLIENTS; it is unchanged if nothing is granted.
- Range check: a granted request with addr ≥ FB_PIXELS is accepted, its port strobe stays 0, and addr_err pulses.
- If a swap and a grant occur in the same cycle, the grant completes and CLEAR starts next cycle.
- Clients must hold valid, addr and data stable until ready.

## Timing
- All write outputs are registered: a handshake or clear step in cycle N produces wrX_en/addrX/dataX in cycle N+1.
- The framebuffer adds its own one-cycle input register.
- Clear duration is FB_PIXELS/2 cycles, 192000 at the default.
- Reset values: every output is 0, including `cc`, the state (ARB) and the registered vsync copy (0).
- Asynchronous reset mid-CLEAR or mid-grant:
  - outputs clear immediately;
  - the partial clear is abandoned;
  - no resume after reset.
- clear_overrun and addr_err are registered and aligned with the cycle N+1 outputs.
- Throughput: at most 2 pixels per cycle. A client holding valid is granted within NUM_CLIENTS cycles in ARB.

## Structure
- Package `fb_pkg`:
  - FB_ADDR_W = 19, FB_DATA_W = 4, FB_PIXELS_DEFAULT = 384000;
  - `typedef enum logic {ARB, CLEAR} fbws_state_t`;
  - `fb_pixel_t` struct holding addr and data.
- Sub-module `fb_rr_pick2`: combinational two-grant round-robin picker.
  - Inputs: valid vector, `rr`, addresses.
  - Outputs: grant1, grant2 indices with valid flags, and next `rr`.
  - Includes the equal-address suppression.

## Test plan
- Reset release: all outputs 0. Single client 0 with addr 5, data 4'hA → ready in cycle 0; wr1_en=1, addr_wr1=5, data_wr1=4'hA in cycle 1; wr2_en=0.
- Four clients valid continuously, all distinct addresses, `rr`=0:
  - grants (0,1), (2,3), (0,1), … → two writes every cycle;
  - each client served every 2 cycles.
- Clients 1 and 2 both request addr 100 with data 3 and 7: cycle 0 grants only client 1 (data 3 on port 1); cycle 1 grants client 2 (data 7); final written value is 7.
- clear_en=1 with a vsync falling edge:
  - clear_busy=1 for 192000 cycles;
  - port pairs (0,1), (2,3) … (383998, 383999) carry CLEAR_COLOR;
  - req_ready stays 0 throughout;
  - ARB resumes afterward.
- Second vsync falling edge at clear step 1000: clear_overrun pulses once and the next write pair is (0,1).
- Client request with addr 384000 → ready=1, wr1_en stays 0, addr_err pulses for 1 cycle.
- Async reset asserted mid-CLEAR: all outputs 0 immediately; after release the state is ARB and there is no clear until the next swap.
